// File: rtl/route_arbiter.sv
// route_arbiter
// Round-robin arbiter for a 4-port router. When idle it picks one requesting
// port, then holds the route for SLOT_CYCLES cycles. After each slot it always
// spends at least one idle (turnaround) cycle.
//
// Parameters
//   SLOT_CYCLES : number of cycles each granted transfer holds the route (1..255)
// Ports
//   clk         : single clock; all state updates on the rising edge
//   reset       : synchronous, active-high reset
//   req[3:0]    : req[i] high when port i wants a transfer
//   dest0..3    : destination output index requested by each port
//   sender      : registered source select for the router
//   receiver    : registered destination select for the router
//   route_valid : high while sender/receiver describe an active transfer
//   grant[3:0]  : one-hot registered grant, all-zero when idle
//   slot_done   : single-cycle pulse on the last cycle of a slot
module route_arbiter #(
  parameter int unsigned SLOT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [1:0] dest0,
  input  logic [1:0] dest1,
  input  logic [1:0] dest2,
  input  logic [1:0] dest3,
  output logic [1:0] sender,
  output logic [1:0] receiver,
  output logic       route_valid,
  output logic [3:0] grant,
  output logic       slot_done
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // The counter holds "cycles left after this one", so a slot loads SLOT_CYCLES-1.
  localparam logic [7:0] CNT_LOAD = 8'(SLOT_CYCLES - 1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [1:0] ptr_r;
  logic [1:0] ptr_nxt_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;
  logic [1:0] sender_nxt_s;
  logic [1:0] receiver_nxt_s;
  logic       valid_nxt_s;
  logic [3:0] grant_nxt_s;
  logic       done_nxt_s;
  logic [1:0] win_s;
  logic       any_s;
  logic [1:0] win_dest_s;

  // Round-robin pick: scan from p upward (mod 4). The loop walks the offsets
  // downward, so the smallest offset with a set request is written last and wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) begin
        pick = idx;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Convert a port index into its one-hot grant vector.
  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Winner selection and the winner's requested destination.
  always_comb begin
    any_s = |req;
    win_s = rr_pick(req, ptr_r);
    case (win_s)
      2'd0:    win_dest_s = dest0;
      2'd1:    win_dest_s = dest1;
      2'd2:    win_dest_s = dest2;
      2'd3:    win_dest_s = dest3;
      default: win_dest_s = dest0;
    endcase
  end

  // Next-state and next-output logic. When idle, sender/receiver keep their
  // last values. Inputs are ignored while a slot is running.
  always_comb begin
    state_nxt_s    = state_r;
    ptr_nxt_s      = ptr_r;
    cnt_nxt_s      = cnt_r;
    sender_nxt_s   = sender;
    receiver_nxt_s = receiver;
    valid_nxt_s    = 1'b0;
    grant_nxt_s    = 4'b0000;
    done_nxt_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          state_nxt_s    = BUSY;
          ptr_nxt_s      = win_s + 2'd1;
          cnt_nxt_s      = CNT_LOAD;
          sender_nxt_s   = win_s;
          receiver_nxt_s = win_dest_s;
          valid_nxt_s    = 1'b1;
          grant_nxt_s    = onehot(win_s);
          // A one-cycle slot is also its own last cycle.
          done_nxt_s     = (CNT_LOAD == 8'd0);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == 8'd0) begin
          // Last slot cycle is now on the outputs: drop to the turnaround cycle.
          state_nxt_s = IDLE;
        end else begin
          cnt_nxt_s   = cnt_r - 8'd1;
          valid_nxt_s = 1'b1;
          grant_nxt_s = grant;
          // slot_done lines up with the cycle whose counter value will be 0.
          done_nxt_s  = (cnt_r == 8'd1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset overrides any pending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      ptr_r       <= 2'd0;
      cnt_r       <= 8'd0;
      sender      <= 2'd0;
      receiver    <= 2'd0;
      route_valid <= 1'b0;
      grant       <= 4'b0000;
      slot_done   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ptr_r       <= ptr_nxt_s;
      cnt_r       <= cnt_nxt_s;
      sender      <= sender_nxt_s;
      receiver    <= receiver_nxt_s;
      route_valid <= valid_nxt_s;
      grant       <= grant_nxt_s;
      slot_done   <= done_nxt_s;
    end
  end

endmodule

// File: doc/route_arbiter.md
ROUTE_ARBITER -- requirements
Module: route_arbiter

Interface
REQ-001 The block SHALL have parameter SLOT_CYCLES, default 4, giving the number of cycles each granted transfer holds the route (legal range 1..255).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  req[i] high means port i requests a transfer.
REQ-005 dest0, dest1, dest2, dest3  input  2 each  destination output index requested by port i.
REQ-006 sender  output  2  registered source select for the router.
REQ-007 receiver  output  2  registered destination select for the router.
REQ-008 route_valid  output  1  high while sender/receiver describe an active transfer.
REQ-009 grant  output  4  one-hot registered grant; bit i high while port i owns the slot, all-zero otherwise.
REQ-010 slot_done  output  1  single-cycle pulse on the last cycle of a slot.

Function
REQ-011 The FSM SHALL have two states: IDLE and BUSY.
REQ-012 IDLE: route_valid=0, grant=4'b0000, slot_done=0; sender/receiver hold their last values.
REQ-013 IDLE with req==0: remain IDLE.
REQ-014 IDLE with any req bit high at edge N: select the winner by round-robin, then enter BUSY; from cycle N+1, sender=winner, receiver=dest_winner sampled at edge N, grant bit set, route_valid=1.
REQ-015 Round-robin: search order starts at pointer ptr and increments modulo 4; the first set req bit wins.
REQ-016 ptr SHALL become (winner+1) mod 4 at the grant edge.
REQ-017 BUSY SHALL last exactly SLOT_CYCLES cycles; a down-counter loaded with SLOT_CYCLES-1 at grant, decrementing each BUSY cycle, with width sufficient for 255.
REQ-018 slot_done SHALL be high in the BUSY cycle where the counter equals 0; the next state is IDLE.
REQ-019 After every slot, the block SHALL spend at least one IDLE cycle (route_valid=0): back-to-back slots are separated by exactly one turnaround cycle when requests are pending.
REQ-020 During BUSY, changes to req or destN SHALL be ignored; dropping req mid-slot SHALL NOT shorten the slot.
REQ-021 dest_winner equal to winner (loopback) SHALL be granted normally.
REQ-022 SLOT_CYCLES=1: route_valid and slot_done SHALL both be high for the same single cycle.
REQ-023 Requests arriving during BUSY SHALL be considered only at the next IDLE cycle.

Reset
REQ-024 On a reset edge, the block SHALL set state=IDLE, sender=0, receiver=0, route_valid=0, grant=0, slot_done=0, ptr=0, counter=0.
REQ-025 Reset asserted mid-slot SHALL abort the slot at that edge with no slot_done pulse.
REQ-026 Reset SHALL take priority over all requests in the same cycle.

Verification
REQ-027 Reset, then req=4'b0001, dest0=2'd3 -> next cycle sender=0, receiver=3, grant=0001, route_valid=1 for 4 cycles, slot_done on 4th, then one IDLE cycle.
REQ-028 req=4'b1111 held constantly, dest=i -> grants in order 0,1,2,3,0; each slot 4 cycles; 1 idle cycle between slots.
REQ-029 Port 2 granted with dest2=1, then dest2 changed to 3 and req[2] dropped in slot cycle 2 -> receiver stays 1, slot still lasts 4 cycles.
REQ-030 reset pulsed in slot cycle 2 -> next cycle all outputs 0, no slot_done; then req=4'b1000 -> port 3 granted (ptr=0 search).
REQ-031 SLOT_CYCLES=1, req=4'b0110 held -> port 1 granted, route_valid and slot_done high together for one cycle, IDLE cycle, then port 2 granted.
REQ-032 ptr=3 after a port-2 grant, req=4'b0011 -> port 0 wins (wrap-around), ptr becomes 1.
